// File: rtl/io_ctrl_if.sv
// Memory-mapped register bus between a CPU-side master and the io_ctrl slave.
interface io_ctrl_if #(
    parameter int unsigned DBITS = 32
) ();
    logic [DBITS-1:0] addr;
    logic [DBITS-1:0] wdata;
    logic             we;
    logic             re;
    logic [DBITS-1:0] rdata;
    logic             rvalid;

    modport master (
        output addr, wdata, we, re,
        input  rdata, rvalid
    );

    modport slave (
        input  addr, wdata, we, re,
        output rdata, rvalid
    );
endinterface

// File: rtl/io_ctrl.sv
// Board I/O controller: hex/LED output registers, debounced keys and switches,
// sticky change status with interrupt enables, all behind a register bus.
module io_ctrl #(
    parameter int unsigned    DBITS  = 32,
    parameter int unsigned    NKEY   = 4,
    parameter int unsigned    NSW    = 10,
    parameter int unsigned    NLEDR  = 10,
    parameter int unsigned    NHEX   = 6,
    parameter int unsigned    DEBCYC = 16,
    parameter logic [DBITS-1:0] BASE = DBITS'(32'hFFFFF000)
) (
    input  logic              clk,
    input  logic              reset,
    io_ctrl_if.slave          bus,
    input  logic [NKEY-1:0]   key_n,
    input  logic [NSW-1:0]    sw,
    output logic [NLEDR-1:0]  ledr,
    output logic [4*NHEX-1:0] hex_digits,
    output logic              irq
);

    // Keys and switches share one debounce array: keys low, switches high.
    localparam int unsigned NCH = NKEY + NSW;
    localparam int unsigned CW  = $clog2(DEBCYC);

    localparam logic [DBITS-1:0] A_HEX   = BASE;
    localparam logic [DBITS-1:0] A_LEDR  = BASE + DBITS'(32'h20);
    localparam logic [DBITS-1:0] A_KDATA = BASE + DBITS'(32'h80);
    localparam logic [DBITS-1:0] A_KSTAT = BASE + DBITS'(32'h84);
    localparam logic [DBITS-1:0] A_KIE   = BASE + DBITS'(32'h88);
    localparam logic [DBITS-1:0] A_SDATA = BASE + DBITS'(32'h90);
    localparam logic [DBITS-1:0] A_SSTAT = BASE + DBITS'(32'h94);
    localparam logic [DBITS-1:0] A_SIE   = BASE + DBITS'(32'h98);

    logic [NCH-1:0]   sync1;
    logic [NCH-1:0]   sync2;
    logic [NCH-1:0]   deb;
    logic [NCH-1:0]   chg;
    logic [CW-1:0]    cnt [NCH];
    logic [NKEY-1:0]  kstat;
    logic [NKEY-1:0]  kie;
    logic [NSW-1:0]   sstat;
    logic [NSW-1:0]   sie;
    logic [NKEY-1:0]  kclr;
    logic [NSW-1:0]   sclr;
    logic [DBITS-1:0] rd_mux;
    logic             wr_hex;
    logic             wr_ledr;
    logic             wr_kstat;
    logic             wr_kie;
    logic             wr_sstat;
    logic             wr_sie;
    logic             unused_wdata;

    assign wr_hex   = bus.we && (bus.addr == A_HEX);
    assign wr_ledr  = bus.we && (bus.addr == A_LEDR);
    assign wr_kstat = bus.we && (bus.addr == A_KSTAT);
    assign wr_kie   = bus.we && (bus.addr == A_KIE);
    assign wr_sstat = bus.we && (bus.addr == A_SSTAT);
    assign wr_sie   = bus.we && (bus.addr == A_SIE);

    assign kclr = wr_kstat ? bus.wdata[NKEY-1:0] : '0;
    assign sclr = wr_sstat ? bus.wdata[NSW-1:0]  : '0;

    // Upper write bits beyond each register width are intentionally dropped.
    assign unused_wdata = ^bus.wdata;

    // Two-flop synchronizer; keys are inverted first so 0 means released everywhere.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {sw, ~key_n};
            sync2 <= sync1;
        end
    end

    // Per-channel debounce: accept a new level after DEBCYC consecutive differing cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb <= '0;
            chg <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                chg[i] <= 1'b0;
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] == CW'(DEBCYC - 1)) begin
                        deb[i] <= sync2[i];
                        cnt[i] <= '0;
                        chg[i] <= 1'b1;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Writable registers; status is W1C with a coincident set taking priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_digits <= '0;
            ledr       <= '0;
            kie        <= '0;
            sie        <= '0;
            kstat      <= '0;
            sstat      <= '0;
        end else begin
            if (wr_hex)  hex_digits <= bus.wdata[4*NHEX-1:0];
            if (wr_ledr) ledr       <= bus.wdata[NLEDR-1:0];
            if (wr_kie)  kie        <= bus.wdata[NKEY-1:0];
            if (wr_sie)  sie        <= bus.wdata[NSW-1:0];
            kstat <= (kstat & ~kclr) | (chg[NKEY-1:0] & deb[NKEY-1:0]);
            sstat <= (sstat & ~sclr) | chg[NCH-1:NKEY];
        end
    end

    // Read decode from current register contents (pre-write on simultaneous we/re).
    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            A_HEX:   rd_mux = DBITS'(hex_digits);
            A_LEDR:  rd_mux = DBITS'(ledr);
            A_KDATA: rd_mux = DBITS'(deb[NKEY-1:0]);
            A_KSTAT: rd_mux = DBITS'(kstat);
            A_KIE:   rd_mux = DBITS'(kie);
            A_SDATA: rd_mux = DBITS'(deb[NCH-1:NKEY]);
            A_SSTAT: rd_mux = DBITS'(sstat);
            A_SIE:   rd_mux = DBITS'(sie);
            default: rd_mux = '0;
        endcase
    end

    // Registered read port: one-cycle rvalid, data zero when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
        end else begin
            bus.rvalid <= bus.re;
            bus.rdata  <= bus.re ? rd_mux : '0;
        end
    end

    // Interrupt is a pure function of status and enable registers.
    assign irq = (|(kstat & kie)) | (|(sstat & sie));

endmodule

// File: tb/tb_io_ctrl.sv
// Directed bench for io_ctrl: register access, key/switch debounce, status/irq, reset.
module tb_io_ctrl;
    localparam int unsigned DEBCYC = 16;
    localparam logic [31:0] BASE   = 32'hFFFFF000;
    localparam logic [31:0] A_HEX   = BASE + 32'h00;
    localparam logic [31:0] A_LEDR  = BASE + 32'h20;
    localparam logic [31:0] A_UNMAP = BASE + 32'h40;
    localparam logic [31:0] A_KDATA = BASE + 32'h80;
    localparam logic [31:0] A_KSTAT = BASE + 32'h84;
    localparam logic [31:0] A_KIE   = BASE + 32'h88;
    localparam logic [31:0] A_SDATA = BASE + 32'h90;
    localparam logic [31:0] A_SSTAT = BASE + 32'h94;
    localparam logic [31:0] A_SIE   = BASE + 32'h98;

    logic        clk;
    logic        reset;
    logic [3:0]  key_n;
    logic [9:0]  sw;
    logic [9:0]  ledr;
    logic [23:0] hex_digits;
    logic        irq;
    int          tests;
    int          fails;
    logic [31:0] rd;
    logic        rv;

    io_ctrl_if #(.DBITS(32)) bus ();

    io_ctrl #(
        .DBITS(32), .NKEY(4), .NSW(10), .NLEDR(10), .NHEX(6),
        .DEBCYC(DEBCYC), .BASE(BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .key_n      (key_n),
        .sw         (sw),
        .ledr       (ledr),
        .hex_digits (hex_digits),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        tick();
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
        bus.addr = a;
        bus.re   = 1'b1;
        tick();
        d        = bus.rdata;
        v        = bus.rvalid;
        bus.re   = 1'b0;
        bus.addr = '0;
    endtask

    task automatic test_reset();
        tests++; if (ledr !== 10'h0) begin fails++; $display("FAIL reset_ledr: got %h want 0", ledr); end
        tests++; if (hex_digits !== 24'h0) begin fails++; $display("FAIL reset_hex: got %h want 0", hex_digits); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b want 0", irq); end
        tests++; if (bus.rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid: got %b want 0", bus.rvalid); end
        bus_read(A_KDATA, rd, rv);
        tests++; if (rd !== 32'h0 || rv !== 1'b1) begin fails++; $display("FAIL reset_kdata: got %h/%b want 0/1", rd, rv); end
    endtask

    task automatic test_hex();
        bus_write(A_HEX, 32'h00123456);
        tests++; if (hex_digits !== 24'h123456) begin fails++; $display("FAIL hex_out: got %h want 123456", hex_digits); end
        bus_read(A_HEX, rd, rv);
        tests++; if (rd !== 32'h00123456 || rv !== 1'b1) begin fails++; $display("FAIL hex_read: got %h/%b want 00123456/1", rd, rv); end
        tick();
        tests++; if (bus.rvalid !== 1'b0 || bus.rdata !== 32'h0) begin fails++; $display("FAIL hex_rvalid_drop: got %b/%h want 0/0", bus.rvalid, bus.rdata); end
    endtask

    task automatic test_ledr_rw();
        bus_write(A_LEDR, 32'hFFFFFFFF);
        tests++; if (ledr !== 10'h3FF) begin fails++; $display("FAIL ledr_trunc: got %h want 3ff", ledr); end
        bus.addr  = A_LEDR;
        bus.wdata = 32'h00000155;
        bus.we    = 1'b1;
        bus.re    = 1'b1;
        tick();
        bus.we    = 1'b0;
        bus.re    = 1'b0;
        tests++; if (bus.rdata !== 32'h3FF || bus.rvalid !== 1'b1) begin fails++; $display("FAIL ledr_rw_prewrite: got %h/%b want 3ff/1", bus.rdata, bus.rvalid); end
        tests++; if (ledr !== 10'h155) begin fails++; $display("FAIL ledr_rw_write: got %h want 155", ledr); end
        bus_read(A_LEDR, rd, rv);
        tests++; if (rd !== 32'h155) begin fails++; $display("FAIL ledr_read: got %h want 155", rd); end
    endtask

    task automatic test_key_press();
        bus_write(A_KIE, 32'h4);
        key_n = 4'b1011;
        repeat (DEBCYC + 2) tick();
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL key_early_irq: got %b want 0", irq); end
        tick();
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL key_latency_irq: got %b want 1", irq); end
        bus_read(A_KDATA, rd, rv);
        tests++; if (rd !== 32'h4) begin fails++; $display("FAIL key_kdata: got %h want 4", rd); end
        bus_read(A_KSTAT, rd, rv);
        tests++; if (rd !== 32'h4) begin fails++; $display("FAIL key_kstat: got %h want 4", rd); end
        key_n = 4'b1111;
        bus_write(A_KSTAT, 32'h4);
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL key_w1c_irq: got %b want 0", irq); end
        repeat (DEBCYC + 4) tick();
        bus_read(A_KDATA, rd, rv);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL key_release_kdata: got %h want 0", rd); end
        bus_read(A_KSTAT, rd, rv);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL key_release_kstat: got %h want 0", rd); end
    endtask

    task automatic test_key_bounce();
        for (int n = 0; n < 3; n++) begin
            key_n = 4'b1110;
            repeat (DEBCYC - 1) tick();
            key_n = 4'b1111;
            repeat (2) tick();
        end
        repeat (DEBCYC + 4) tick();
        bus_read(A_KDATA, rd, rv);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL bounce_kdata: got %h want 0", rd); end
        bus_read(A_KSTAT, rd, rv);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL bounce_kstat: got %h want 0", rd); end
    endtask

    task automatic test_unmapped();
        bus_read(A_UNMAP, rd, rv);
        tests++; if (rd !== 32'h0 || rv !== 1'b1) begin fails++; $display("FAIL unmapped_read: got %h/%b want 0/1", rd, rv); end
        bus_write(A_KDATA, 32'hF);
        bus_read(A_KDATA, rd, rv);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL ro_write_kdata: got %h want 0", rd); end
    endtask

    task automatic test_switch_w1c();
        bus_write(A_SIE, 32'h200);
        sw = 10'h200;
        repeat (DEBCYC + 2) tick();
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL sw_early_irq: got %b want 0", irq); end
        bus.addr  = A_SSTAT;
        bus.wdata = 32'h200;
        bus.we    = 1'b1;
        tick();
        bus.we    = 1'b0;
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL sw_set_wins_irq: got %b want 1", irq); end
        bus_read(A_SSTAT, rd, rv);
        tests++; if (rd !== 32'h200) begin fails++; $display("FAIL sw_sstat: got %h want 200", rd); end
        bus_read(A_SDATA, rd, rv);
        tests++; if (rd !== 32'h200) begin fails++; $display("FAIL sw_sdata: got %h want 200", rd); end
        bus_write(A_SSTAT, 32'h200);
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL sw_w1c_irq: got %b want 0", irq); end
    endtask

    task automatic test_reset_mid();
        bus_write(A_KIE, 32'h8);
        bus_write(A_LEDR, 32'h0AA);
        key_n = 4'b0111;
        repeat (DEBCYC + 4) tick();
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL rst_pre_irq: got %b want 1", irq); end
        key_n = 4'b0101;
        sw    = 10'h201;
        repeat (5) tick();
        bus.addr = A_LEDR;
        bus.re   = 1'b1;
        tick();
        bus.re   = 1'b0;
        tests++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0AA) begin fails++; $display("FAIL rst_pre_read: got %b/%h want 1/000000aa", bus.rvalid, bus.rdata); end
        #2 reset = 1'b1;
        #1;
        tests++; if (bus.rvalid !== 1'b0 || bus.rdata !== 32'h0) begin fails++; $display("FAIL rst_async_bus: got %b/%h want 0/0", bus.rvalid, bus.rdata); end
        tests++; if (ledr !== 10'h0 || hex_digits !== 24'h0) begin fails++; $display("FAIL rst_async_out: got %h/%h want 0/0", ledr, hex_digits); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL rst_async_irq: got %b want 0", irq); end
        repeat (2) tick();
        reset = 1'b0;
        tick();
        tests++; if (bus.rvalid !== 1'b0) begin fails++; $display("FAIL rst_stale_rvalid: got %b want 0", bus.rvalid); end
        bus_read(A_KDATA, rd, rv);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL rst_kdata_cleared: got %h want 0", rd); end
        repeat (DEBCYC + 4) tick();
        bus_read(A_KDATA, rd, rv);
        tests++; if (rd !== 32'hA) begin fails++; $display("FAIL rst_kdata_redo: got %h want a", rd); end
        bus_read(A_KSTAT, rd, rv);
        tests++; if (rd !== 32'hA) begin fails++; $display("FAIL rst_kstat_redo: got %h want a", rd); end
        bus_read(A_SSTAT, rd, rv);
        tests++; if (rd !== 32'h201) begin fails++; $display("FAIL rst_sstat_high_sw: got %h want 201", rd); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL rst_irq_enables_cleared: got %b want 0", irq); end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        key_n     = 4'hF;
        sw        = 10'h0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.we    = 1'b0;
        bus.re    = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        test_reset();
        test_hex();
        test_ledr_rw();
        test_key_press();
        test_key_bounce();
        test_unmapped();
        test_switch_w1c();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
